// File: rtl/tdm_demux4.sv
// Slot-synchronous deserialiser for a paired dual 4:1 multiplexer: drives the
// shared slot select and rebuilds one 4-bit word per channel per frame.
module tdm_demux4 #(
  parameter int FREE_RUN = 1
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       SYNC,
  input  logic       Za,
  input  logic       Zb,
  input  logic       nEa,
  input  logic       nEb,
  output logic       S0,
  output logic       S1,
  output logic [3:0] Qa,
  output logic [3:0] Qb,
  output logic       VALIDa,
  output logic       VALIDb,
  output logic       ERR
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam state_t RESET_STATE = (FREE_RUN != 0) ? RUN : IDLE;

  state_t     state_reg, state_next;
  logic [1:0] slot_reg, slot_next;
  logic [2:0] shadow_a_reg, shadow_a_next;
  logic [2:0] shadow_b_reg, shadow_b_next;
  logic       en_a_reg, en_a_next;
  logic       en_b_reg, en_b_next;
  logic [3:0] qa_reg, qa_next;
  logic [3:0] qb_reg, qb_next;
  logic       valida_reg, valida_next;
  logic       validb_reg, validb_next;
  logic       err_reg, err_next;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg    <= RESET_STATE;
      slot_reg     <= 2'd0;
      shadow_a_reg <= 3'd0;
      shadow_b_reg <= 3'd0;
      en_a_reg     <= 1'b1;
      en_b_reg     <= 1'b1;
      qa_reg       <= 4'h0;
      qb_reg       <= 4'h0;
      valida_reg   <= 1'b0;
      validb_reg   <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      slot_reg     <= slot_next;
      shadow_a_reg <= shadow_a_next;
      shadow_b_reg <= shadow_b_next;
      en_a_reg     <= en_a_next;
      en_b_reg     <= en_b_next;
      qa_reg       <= qa_next;
      qb_reg       <= qb_next;
      valida_reg   <= valida_next;
      validb_reg   <= validb_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    slot_next     = slot_reg;
    shadow_a_next = shadow_a_reg;
    shadow_b_next = shadow_b_reg;
    en_a_next     = en_a_reg;
    en_b_next     = en_b_reg;
    qa_next       = qa_reg;
    qb_next       = qb_reg;
    valida_next   = 1'b0;
    validb_next   = 1'b0;
    err_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        slot_next = 2'd0;
        en_a_next = 1'b1;
        en_b_next = 1'b1;
        if (SYNC) state_next = RUN;
      end
      RUN: begin
        if (SYNC && (slot_reg != 2'd3)) begin
          // Misaligned marker: drop the partial frame and restart at slot 0.
          slot_next = 2'd0;
          err_next  = 1'b1;
          en_a_next = 1'b1;
          en_b_next = 1'b1;
        end else begin
          slot_next = slot_reg + 2'd1;
          if (slot_reg == 2'd3) begin
            // Last bit bypasses the shadow so the word lands one cycle after it.
            if (en_a_reg && !nEa) begin
              qa_next     = {Za, shadow_a_reg};
              valida_next = 1'b1;
            end
            if (en_b_reg && !nEb) begin
              qb_next     = {Zb, shadow_b_reg};
              validb_next = 1'b1;
            end
            en_a_next = 1'b1;
            en_b_next = 1'b1;
          end else begin
            shadow_a_next[slot_reg] = Za;
            shadow_b_next[slot_reg] = Zb;
            en_a_next = en_a_reg & ~nEa;
            en_b_next = en_b_reg & ~nEb;
          end
        end
      end
      default: begin
        state_next = RESET_STATE;
        slot_next  = 2'd0;
      end
    endcase
  end

  assign S0     = slot_reg[0];
  assign S1     = slot_reg[1];
  assign Qa     = qa_reg;
  assign Qb     = qb_reg;
  assign VALIDa = valida_reg;
  assign VALIDb = validb_reg;
  assign ERR    = err_reg;

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 The block SHALL have parameter FREE_RUN, default 1, meaning 1 = slot counter runs from reset, 0 = counter waits in IDLE for first SYNC.
REQ-002 The block SHALL have port CLK, input, 1, system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port nRST, input, 1, reset; asynchronous, active-low.
REQ-004 The block SHALL have port SYNC, input, 1, frame marker; high = next cycle is slot 0.
REQ-005 The block SHALL have ports Za and Zb, inputs, 1 each, serial data from the paired dual 4:1 multiplexer outputs.
REQ-006 The block SHALL have ports nEa and nEb, inputs, 1 each, copies of the multiplexer section strobes; low = section enabled.
REQ-007 The block SHALL have ports S0 and S1, outputs, 1 each, slot select driven to the multiplexer; {S1,S0} = current slot.
REQ-008 The block SHALL have ports Qa and Qb, outputs, 4 each, deserialised words; bit k = Z sampled in slot k.
REQ-009 The block SHALL have ports VALIDa and VALIDb, outputs, 1 each, one-cycle strobe, high in the cycle a new Q word first appears.
REQ-010 The block SHALL have port ERR, output, 1, one-cycle pulse on frame misalignment.

Function
REQ-011 The block SHALL implement states IDLE and RUN; IDLE holds slot = 0 and captures nothing; RUN advances slot 0->1->2->3->0 on each CLK edge.
REQ-012 With FREE_RUN = 1, the block SHALL leave reset in RUN; with FREE_RUN = 0, it SHALL leave reset in IDLE and go to RUN on the first edge with SYNC = 1, with slot 0 in the following cycle.
REQ-013 S1 and S0 SHALL be registered outputs equal to the slot counter, with zero combinational path from any input.
REQ-014 In RUN, on the edge ending slot k, the block SHALL store Za and Zb into shadow bit k of each channel; the slot-3 edge SHALL use Za and Zb directly.
REQ-015 On the edge ending slot 3, Qa SHALL load {Za, shadow_a[2:0]} and VALIDa SHALL go high for exactly one cycle, only if nEa was low at all four sampling edges of that frame; otherwise Qa SHALL hold and VALIDa SHALL stay low. Channel b SHALL follow the same rule independently with Qb, VALIDb and nEb.
REQ-016 Latency SHALL be 1 cycle from the slot-3 sample to the Q/VALID update, which gives 4 cycles from the slot-0 sample.
REQ-017 SYNC on the edge ending slot 3 SHALL be aligned: normal frame completion and no ERR.
REQ-018 SYNC in RUN on the edge ending slot 0, 1 or 2 SHALL force the next slot to 0, discard the partial frame (no Q update, no VALID), and pulse ERR high for one cycle.
REQ-019 SYNC in IDLE SHALL NOT assert ERR.
REQ-020 Section disable SHALL NOT stop the counter; the two channels SHALL share the slot counter.
REQ-021 After slot 3 the counter SHALL wrap to 0 with no idle cycle, so back-to-back frames produce a VALID every 4 cycles.

Reset
REQ-022 While nRST = 0, the block SHALL asynchronously force slot = 0, S1 = S0 = 0, Qa = Qb = 4'h0, shadows = 0, VALIDa = VALIDb = 0, ERR = 0, and frame-enable tracking to "all enabled".
REQ-023 Reset asserted mid-frame SHALL discard the partial frame with no VALID on release.
REQ-024 On reset release, the state SHALL be RUN if FREE_RUN = 1, otherwise IDLE.
REQ-025 The first RUN cycle after reset release SHALL be slot 0.

Verification
REQ-026 FREE_RUN=1, nEa=nEb=0, Za serial 1,0,1,1 and Zb 0,1,1,0 over slots 0..3 -> Qa=4'hD, Qb=4'h6, VALIDa=VALIDb=1 for one cycle, 4 cycles after the slot-0 sample.
REQ-027 Back-to-back frames Qa=4'h5 then 4'hA -> VALIDa pulses exactly 4 cycles apart; S1S0 sequence 00,01,10,11,00 with no gap.
REQ-028 nEa=1 in slot 2 only, Zb frame 4'h9 -> Qa holds its previous value, VALIDa=0; Qb=4'h9, VALIDb=1.
REQ-029 SYNC asserted on the edge ending slot 1 -> ERR=1 for one cycle, next S1S0=00, no VALID for the truncated frame; the next full frame decodes correctly.
REQ-030 FREE_RUN=0, data toggling, no SYNC for 10 cycles -> S1S0 stays 00 and VALID stays 0; then SYNC pulse -> slot 0 follows, first frame decodes, ERR stays 0.
REQ-031 nRST pulsed low during slot 2 -> all outputs 0 immediately (asynchronously), no VALID after release, and decoding resumes at slot 0.
